// File: rtl/pixel_hit_capture.sv
// pixel_hit_capture: synchronizes the pulse-generator strobe into the
// bunch-crossing clock and records one hit bit per crossing in a circular
// buffer, with TDC data stored only on hits. An L1A reads back the crossing
// recorded `latency` cycles earlier. A saturating hit counter feeds
// slow control.
// Optional feature macro: PIXEL_HIT_PARITY_EN (stores an even-parity bit per
// data entry and flags mismatches on readback).
module pixel_hit_capture #(
    parameter int unsigned DATA_WIDTH = 29,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pulseN,
    input  logic [DATA_WIDTH-1:0] tdcData,
    input  logic [ADDR_WIDTH-1:0] latency,
    input  logic                  l1a,
    output logic                  l1Valid,
    output logic                  l1Hit,
    output logic [DATA_WIDTH-1:0] l1Data,
    output logic [CNT_WIDTH-1:0]  hitCount,
    output logic                  parityErr
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef PIXEL_HIT_PARITY_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
`endif

    logic                  s1_q, s2_q, s3_q;
    logic                  hitEvt;
    logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [CNT_WIDTH-1:0]  hitCount_q, hitCount_d;
    logic [DEPTH-1:0]      hit_q;
    logic [MEM_W-1:0]      mem_q [DEPTH];
    logic [MEM_W-1:0]      wrWord;
    logic [MEM_W-1:0]      rdWord;
    logic                  rdHit;
    logic                  l1Valid_q;
    logic                  l1Hit_q;
    logic [DATA_WIDTH-1:0] l1Data_q;

    // Falling edge of the synchronized strobe; s3 must be high, so a strobe
    // re-asserted before s2 has returned high merges with the current one.
    assign hitEvt = s3_q & ~s2_q & enable;

    // Reads sample the array before this edge's write (read-before-write).
    assign rdAddr = wrAddr_q - latency;
    assign rdWord = mem_q[rdAddr];
    assign rdHit  = hit_q[rdAddr];

`ifdef PIXEL_HIT_PARITY_EN
    assign wrWord = {^tdcData, tdcData};
`else
    assign wrWord = tdcData;
`endif

    // Next-state for the write pointer and the saturating hit counter
    always_comb begin
        wrAddr_d   = wrAddr_q + 1'b1;
        hitCount_d = hitCount_q;
        if (hitEvt && (hitCount_q != '1)) begin
            hitCount_d = hitCount_q + 1'b1;
        end
    end

    // Strobe synchronizer, edge-history flop, pointer, counter and hit bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            wrAddr_q   <= '0;
            hitCount_q <= '0;
            hit_q      <= '0;
        end else begin
            s1_q            <= pulseN;
            s2_q            <= s1_q;
            s3_q            <= s2_q;
            wrAddr_q        <= wrAddr_d;
            hitCount_q      <= hitCount_d;
            hit_q[wrAddr_q] <= hitEvt;
        end
    end

    // Data array: not reset, written only on a hit so old words persist
    always_ff @(posedge clk) begin
        if (hitEvt) begin
            mem_q[wrAddr_q] <= wrWord;
        end
    end

    // L1A readback register; one valid cycle per accepted trigger
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l1Valid_q <= 1'b0;
            l1Hit_q   <= 1'b0;
            l1Data_q  <= '0;
        end else begin
            l1Valid_q <= l1a;
            if (l1a) begin
                l1Hit_q  <= rdHit;
                l1Data_q <= rdHit ? rdWord[DATA_WIDTH-1:0] : '0;
            end
        end
    end

`ifdef PIXEL_HIT_PARITY_EN
    logic parityErr_q;

    // Parity check registered alongside the read result; zero without a hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parityErr_q <= 1'b0;
        end else if (l1a) begin
            parityErr_q <= rdHit & (^rdWord);
        end else begin
            parityErr_q <= 1'b0;
        end
    end

    assign parityErr = parityErr_q;
`else
    assign parityErr = 1'b0;
`endif

    assign l1Valid  = l1Valid_q;
    assign l1Hit    = l1Hit_q;
    assign l1Data   = l1Data_q;
    assign hitCount = hitCount_q;

endmodule

// File: tb/tb_pixel_hit_capture.sv
// Directed bench for pixel_hit_capture: a scoreboard queue holds the expected
// readback for each L1A, built from a record of which absolute crossing held
// which hit. A second instance with a 4-bit counter covers saturation.
module tb_pixel_hit_capture;

    localparam int DW    = 29;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset, enable, pulseN, l1a;
    logic [DW-1:0] tdcData;
    logic [AW-1:0] latency;

    logic          l1Valid, l1Hit, parityErr;
    logic [DW-1:0] l1Data;
    logic [15:0]   hitCount;

    logic          l1Valid4, l1Hit4, parityErr4;
    logic [DW-1:0] l1Data4;
    logic [3:0]    hitCount4;

    pixel_hit_capture dut (
        .clk(clk), .reset(reset), .enable(enable), .pulseN(pulseN),
        .tdcData(tdcData), .latency(latency), .l1a(l1a),
        .l1Valid(l1Valid), .l1Hit(l1Hit), .l1Data(l1Data),
        .hitCount(hitCount), .parityErr(parityErr)
    );

    pixel_hit_capture #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .pulseN(pulseN),
        .tdcData(tdcData), .latency(latency), .l1a(l1a),
        .l1Valid(l1Valid4), .l1Hit(l1Hit4), .l1Data(l1Data4),
        .hitCount(hitCount4), .parityErr(parityErr4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] hitData [int];   // absolute crossing index -> stored word
    int            checks   = 0;
    int            failures = 0;
    int            cyc;             // edges since reset release == wrAddr (mod depth)
    int            nHits    = 0;
    int            flipAt   = -1;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 50000) begin
            step();
            guard++;
        end
        chk("reach_cycle", cyc, target);
    endtask

    // Strobe falls at a negedge when wrAddr=c: s1 low after edge c+1, s2 low
    // after edge c+2, so the hitEvt cycle has wrAddr W=c+2.
    task automatic pulse(input logic [DW-1:0] d, output int w);
        tdcData = d;
        pulseN  = 1'b0;
        w       = cyc + 2;
        if (enable) begin
            hitData[w] = d;
            nHits++;
        end
        repeat (2) step();
        pulseN = 1'b1;
        repeat (2) step();
    endtask

    function automatic exp_t expect_at(input int n);
        exp_t e;
        int   t;
        t      = n - ((latency == 0) ? DEPTH : int'(latency));
        e.hit  = hitData.exists(t);
        e.data = e.hit ? hitData[t] : '0;
        e.perr = e.hit && (t == flipAt);
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_valid"}, l1Valid, 1'b1);
            chk({tag, "_hit"}, l1Hit, e.hit);
            chk({tag, "_data"}, l1Data, e.data);
            chk({tag, "_perr"}, parityErr, e.perr);
            chk({tag, "_hit4"}, l1Hit4, e.hit);
        end
    endtask

    task automatic l1a_burst(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            l1a = 1'b1;
            sbq.push_back(expect_at(cyc));
            step();
            check_out(tag);
        end
        l1a = 1'b0;
        step();
        chk({tag, "_valid_drop"}, l1Valid, 1'b0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_count"}, hitCount, nHits);
        chk({tag, "_count4"}, hitCount4, (nHits > 15) ? 15 : nHits);
    endtask

    initial begin
        int w, lastW, tgt, lat;
        int ws[3];

        reset   = 1'b1;
        enable  = 1'b1;
        pulseN  = 1'b1;
        tdcData = '0;
        latency = '0;
        l1a     = 1'b0;
        repeat (3) step();
        chk("rst_valid", l1Valid, 1'b0);
        chk("rst_hit", l1Hit, 1'b0);
        chk("rst_data", l1Data, '0);
        chk("rst_count", hitCount, '0);
        chk("rst_perr", parityErr, 1'b0);
        reset = 1'b0;

        // Reset readback
        latency = 9'd37;
        l1a_burst("rst_read", 1);

        // Enable low: strobes ignored, reads still served
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(29'h100 + 29'(i), ws[i]);
        latency = 9'd20;
        for (int i = 0; i < 3; i++) begin
            wait_until(ws[i] + 20);
            l1a_burst("en_low", 1);
        end
        chk_counts("en_low");
        enable = 1'b1;

        // Single hit, read at latency-1, latency, latency+1
        latency = 9'd100;
        pulse(29'h0ABCDEF1, w);
        chk_counts("single");
        wait_until(w + 99);
        l1a_burst("single", 3);

        // Wrap-around: hit at wrAddr 510, read when wrAddr wraps to 3
        latency = 9'd5;
        tgt = cyc + ((508 - (cyc % DEPTH) + DEPTH) % DEPTH);
        wait_until(tgt);
        pulse(29'h1234567, w);
        wait_until(w + 5);
        l1a_burst("wrap", 1);
        chk_counts("wrap");

        // Collision at latency 0: read in the hitEvt cycle returns the old entry
        latency = 9'd0;
        tdcData = 29'h15A5A5A5;
        pulseN  = 1'b0;
        w       = cyc + 2;
        step();
        step();
        l1a = 1'b1;
        sbq.push_back(expect_at(cyc));
        hitData[w] = 29'h15A5A5A5;
        nHits++;
        pulseN = 1'b1;
        step();
        check_out("collide");
        l1a = 1'b0;
        step();
        chk("collide_valid_drop", l1Valid, 1'b0);
        // One full buffer lap later the same address returns the new hit
        wait_until(w + DEPTH);
        l1a_burst("collide_lap", 1);
        l1a_burst("b2b", 4);

        // Saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) pulse(29'h0F00000 + 29'(i * 7), lastW);
        chk_counts("sat");
        latency = 9'd3;
        l1a_burst("sat_read", 2);

`ifdef PIXEL_HIT_PARITY_EN
        // Corrupt a stored data bit; the readback must flag it
        latency = 9'd3;
        pulse(29'h0055AA33, w);
        lastW = w;
        dut.mem_q[w % DEPTH][0] = ~dut.mem_q[w % DEPTH][0];
        hitData[w] = hitData[w] ^ 29'h1;
        flipAt = w;
        wait_until(w + 3);
        l1a_burst("parity", 1);
`endif

        // Reset mid-operation drops the in-flight L1A and clears hit bits
        l1a = 1'b1;
        #1 reset = 1'b1;
        step();
        chk("midrst_valid", l1Valid, 1'b0);
        chk("midrst_count", hitCount, '0);
        chk("midrst_count4", hitCount4, '0);
        l1a = 1'b0;
        step();
        reset = 1'b0;
        hitData.delete();
        nHits  = 0;
        flipAt = -1;
        lat = (DEPTH + 2 - (lastW % DEPTH)) % DEPTH;
        if (lat > 2) begin
            latency = AW'(lat);
            wait_until(2);
            l1a_burst("midrst_read", 1);
        end

        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
